mc_control_fsm: RTL and testbench

Multi-cycle control unit for the MIPS-subset CPU. It sequences the program counter register, instruction register, register file, ALU and unified memory port through fetch/decode/execute/memory/writeback steps. It generates the PC write enable consumed by the PC register, and all datapath mux selects. It stalls on a memory ready handshake.

---
 rtl/mc_control_fsm_if.sv | 35 +++
 rtl/mc_control_fsm.sv | 156 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control/datapath bundle between the multi-cycle control FSM and the MIPS datapath.
// slave = control unit side, master = datapath (or bench) side.
interface mc_control_fsm_if;
    logic [5:0] i_opcode;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_pc_w_c;
    logic       o_iord;
    logic       o_mem_rd;
    logic       o_mem_wr;
    logic       o_ir_w;
    logic       o_reg_dst;
    logic       o_mem_to_reg;
    logic       o_reg_w;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_alu_op;
    logic [1:0] o_pc_src;
    logic [3:0] o_state;
    logic       o_illegal;

    modport slave (
        input  i_opcode, i_zero, i_mem_ready,
        output o_pc_w_c, o_iord, o_mem_rd, o_mem_wr, o_ir_w, o_reg_dst,
               o_mem_to_reg, o_reg_w, o_alu_src_a, o_alu_src_b, o_alu_op,
               o_pc_src, o_state, o_illegal
    );

    modport master (
        output i_opcode, i_zero, i_mem_ready,
        input  o_pc_w_c, o_iord, o_mem_rd, o_mem_wr, o_ir_w, o_reg_dst,
               o_mem_to_reg, o_reg_w, o_alu_src_a, o_alu_src_b, o_alu_op,
               o_pc_src, o_state, o_illegal
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/mem/writeback.
// Latency: 3-5 cycles per instruction; outputs Moore from state, except pc_w_c/ir_w/illegal.
// Backpressure: stalls in FETCH/MEMRD/MEMWR until i_mem_ready.
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mc_control_fsm_if.slave  bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = bus.i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (bus.i_opcode == OP_LW || bus.i_opcode == OP_SW) state_d = S_MEMADR;
                else if (bus.i_opcode == OP_RTYPE)                  state_d = S_EXEC;
                else if (bus.i_opcode == OP_BEQ)                    state_d = S_BRANCH;
                else if (bus.i_opcode == OP_J)                      state_d = S_JUMP;
                else if (bus.i_opcode == OP_ADDI)                   state_d = S_ADDIEX;
                else                                                state_d = S_FETCH;
            end
            // Only LW/SW reach MEMADR; anything else here means a corrupted IR, so refetch.
            S_MEMADR: begin
                if (bus.i_opcode == OP_LW)      state_d = S_MEMRD;
                else if (bus.i_opcode == OP_SW) state_d = S_MEMWR;
                else                            state_d = S_FETCH;
            end
            S_MEMRD:  state_d = bus.i_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.i_mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    logic       pc_w_c, iord, mem_rd, mem_wr, ir_w, reg_dst, mem_to_reg, reg_w;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;

    always_comb begin
        pc_w_c     = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_w       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_w      = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_w      = bus.i_mem_ready;
                pc_w_c    = bus.i_mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = !(bus.i_opcode == OP_RTYPE || bus.i_opcode == OP_LW ||
                              bus.i_opcode == OP_SW    || bus.i_opcode == OP_BEQ ||
                              bus.i_opcode == OP_J     || bus.i_opcode == OP_ADDI);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                reg_w      = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_w_c    = bus.i_zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_w_c = 1'b1;
            end
            S_ADDIWB: reg_w = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_pc_w_c     = pc_w_c;
    assign bus.o_iord       = iord;
    assign bus.o_mem_rd     = mem_rd;
    assign bus.o_mem_wr     = mem_wr;
    assign bus.o_ir_w       = ir_w;
    assign bus.o_reg_dst    = reg_dst;
    assign bus.o_mem_to_reg = mem_to_reg;
    assign bus.o_reg_w      = reg_w;
    assign bus.o_alu_src_a  = alu_src_a;
    assign bus.o_alu_src_b  = alu_src_b;
    assign bus.o_alu_op     = alu_op;
    assign bus.o_pc_src     = pc_src;
    assign bus.o_state      = state_q;
    assign bus.o_illegal    = illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm against an instruction-level sequence model.
module tb_mc_control_fsm;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    mc_control_fsm_if bus();

    mc_control_fsm dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic is_legal(input logic [5:0] o);
        return o == T_RTYPE || o == T_LW || o == T_SW || o == T_BEQ || o == T_J || o == T_ADDI;
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] o;
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
        return o;
    endfunction

    // Control word required for a state (by number) given the live inputs:
    // {pc_w_c, iord, mem_rd, mem_wr, ir_w, reg_dst, mem_to_reg, reg_w, src_a, src_b, alu_op, pc_src, illegal}
    function automatic logic [16:0] exp_out(input int st, input logic rdy, input logic z, input logic [5:0] opc);
        logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, sa, ill;
        logic [1:0] sb, aop, psrc;
        {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, sa, ill} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            1:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin sb = 2'b11; ill = !is_legal(opc); end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin sa = 1; aop = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin sa = 1; aop = 2'b01; psrc = 2'b01; pcw = z; end
            10: begin psrc = 2'b10; pcw = 1; end
            11: begin sa = 1; sb = 2'b10; end
            12: rw = 1;
            default: ;
        endcase
        return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, psrc, ill};
    endfunction

    function automatic logic [16:0] dut_out();
        return {bus.o_pc_w_c, bus.o_iord, bus.o_mem_rd, bus.o_mem_wr, bus.o_ir_w, bus.o_reg_dst,
                bus.o_mem_to_reg, bus.o_reg_w, bus.o_alu_src_a, bus.o_alu_src_b, bus.o_alu_op,
                bus.o_pc_src, bus.o_illegal};
    endfunction

    // One clock of an instruction: drive at negedge, compare 1ns later, end on posedge.
    // Inputs the FSM must ignore in this state are randomized.
    task automatic do_step(input int st, input logic [5:0] opc, input logic z, input logic rdy,
                           output logic pcw);
        logic [16:0] exp;
        @(negedge i_clk);
        bus.i_opcode    = (st == 2 || st == 3) ? opc : 6'($urandom);
        bus.i_zero      = (st == 9) ? z : 1'($urandom);
        bus.i_mem_ready = (st == 1 || st == 4 || st == 6) ? rdy : 1'($urandom);
        #1;
        exp = exp_out(st, bus.i_mem_ready, bus.i_zero, bus.i_opcode);
        checks++;
        if (bus.o_state !== 4'(st)) begin
            errors++;
            $display("FAIL state: op=%b got %0d expected %0d", opc, bus.o_state, st);
        end
        checks++;
        if (dut_out() !== exp) begin
            errors++;
            $display("FAIL outputs st=%0d op=%b: got %b expected %b", st, opc, dut_out(), exp);
        end
        checks++;
        if (bus.o_mem_rd === 1'b1 && bus.o_mem_wr === 1'b1) begin
            errors++;
            $display("FAIL mem_rd_wr_excl: got both 1 expected at most one");
        end
        pcw = bus.o_pc_w_c;
        @(posedge i_clk);
    endtask

    // Instruction-level model: state path from FETCH back to FETCH, with stalls.
    task automatic run_instr(input logic [5:0] opc, input logic z, input int fstall, input int mstall);
        int   st_q[$];
        logic rdy_q[$];
        logic p;
        int   pcw_cnt = 0;
        int   exp_pcw;
        for (int i = 0; i < fstall; i++) begin st_q.push_back(1); rdy_q.push_back(1'b0); end
        st_q.push_back(1); rdy_q.push_back(1'b1);
        st_q.push_back(2); rdy_q.push_back(1'b0);
        case (opc)
            T_RTYPE: begin st_q.push_back(7); st_q.push_back(8); rdy_q.push_back(0); rdy_q.push_back(0); end
            T_ADDI:  begin st_q.push_back(11); st_q.push_back(12); rdy_q.push_back(0); rdy_q.push_back(0); end
            T_BEQ:   begin st_q.push_back(9); rdy_q.push_back(0); end
            T_J:     begin st_q.push_back(10); rdy_q.push_back(0); end
            T_LW, T_SW: begin
                int mst;
                mst = (opc == T_LW) ? 4 : 6;
                st_q.push_back(3); rdy_q.push_back(0);
                for (int i = 0; i < mstall; i++) begin st_q.push_back(mst); rdy_q.push_back(1'b0); end
                st_q.push_back(mst); rdy_q.push_back(1'b1);
                if (opc == T_LW) begin st_q.push_back(5); rdy_q.push_back(0); end
            end
            default: ;
        endcase
        foreach (st_q[i]) begin
            do_step(st_q[i], opc, z, rdy_q[i], p);
            if (p === 1'b1) pcw_cnt++;
        end
        exp_pcw = 1 + ((opc == T_J) ? 1 : (opc == T_BEQ) ? int'(z) : 0);
        checks++;
        if (pcw_cnt != exp_pcw) begin
            errors++;
            $display("FAIL pc_write_count op=%b: got %0d expected %0d", opc, pcw_cnt, exp_pcw);
        end
    endtask

    task automatic test_reset();
        logic p;
        bus.i_opcode = '0; bus.i_zero = 1'b0; bus.i_mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            bus.i_opcode = 6'($urandom); bus.i_zero = 1'($urandom); bus.i_mem_ready = 1'($urandom);
            #1;
            checks++;
            if (bus.o_state !== 4'd0 || dut_out() !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs: got state=%0d out=%b expected 0/0", bus.o_state, dut_out());
            end
        end
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        do_step(0, T_RTYPE, 1'b0, 1'b1, p);
        run_instr(T_RTYPE, 1'b0, 0, 0);
    endtask

    task automatic test_rtype_lw();
        run_instr(T_RTYPE, 1'b0, 0, 0);
        run_instr(T_LW, 1'b0, 0, 0);
        run_instr(T_ADDI, 1'b0, 0, 0);
    endtask

    task automatic test_beq();
        run_instr(T_BEQ, 1'b1, 0, 0);
        run_instr(T_BEQ, 1'b0, 0, 0);
    endtask

    task automatic test_mem_stall();
        run_instr(T_SW, 1'b0, 0, 3);
        run_instr(T_RTYPE, 1'b0, 2, 0);
        run_instr(T_LW, 1'b0, 1, 2);
    endtask

    task automatic test_illegal_jump();
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(T_J, 1'b0, 0, 0);
        run_instr(rand_illegal(), 1'b1, 1, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops[0] = T_RTYPE; ops[1] = T_LW; ops[2] = T_SW; ops[3] = T_BEQ;
        ops[4] = T_J; ops[5] = T_ADDI; ops[6] = 6'b111111;
        for (int n = 0; n < 40; n++) begin
            logic [5:0] o;
            o = ops[$urandom_range(0, 6)];
            if (o == 6'b111111) o = rand_illegal();
            run_instr(o, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    // Latency measured purely from o_state returning to FETCH, with memory always ready.
    task automatic test_latency();
        logic [5:0] ops [6];
        int         lat [6];
        ops[0] = T_RTYPE; lat[0] = 4;
        ops[1] = T_LW;    lat[1] = 5;
        ops[2] = T_SW;    lat[2] = 4;
        ops[3] = T_BEQ;   lat[3] = 3;
        ops[4] = T_J;     lat[4] = 3;
        ops[5] = T_ADDI;  lat[5] = 4;
        for (int k = 0; k < 6; k++) begin
            int cnt = 0;
            bus.i_opcode = ops[k]; bus.i_mem_ready = 1'b1; bus.i_zero = 1'($urandom);
            for (int c = 0; c < 20; c++) begin
                @(posedge i_clk);
                #1;
                cnt++;
                if (bus.o_state === 4'd1) break;
            end
            checks++;
            if (cnt != lat[k]) begin
                errors++;
                $display("FAIL latency op=%b: got %0d expected %0d", ops[k], cnt, lat[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic p;
        do_step(1, T_LW, 1'b0, 1'b1, p);
        do_step(2, T_LW, 1'b0, 1'b0, p);
        do_step(3, T_LW, 1'b0, 1'b0, p);
        do_step(4, T_LW, 1'b0, 1'b0, p);
        @(negedge i_clk);
        bus.i_mem_ready = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_state !== 4'd0 || bus.o_mem_rd !== 1'b0 || dut_out() !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d mem_rd=%b out=%b expected 0/0/0",
                     bus.o_state, bus.o_mem_rd, dut_out());
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge i_clk);
            #1;
            checks++;
            if (bus.o_reg_w !== 1'b0 || bus.o_state !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold: got state=%0d reg_w=%b expected 0/0", bus.o_state, bus.o_reg_w);
            end
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (bus.o_reg_w !== 1'b0 || bus.o_state !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got state=%0d reg_w=%b expected 0/0", bus.o_state, bus.o_reg_w);
        end
        @(posedge i_clk);
        run_instr(T_ADDI, 1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_rtype_lw();
        test_beq();
        test_mem_stall();
        test_illegal_jump();
        test_random();
        test_latency();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
